// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - shared encodings, states and width helpers for the Connect-N board controller
package board_pkg;

    localparam logic [1:0] CMD_REDRAW = 2'b00;
    localparam logic [1:0] CMD_RIGHT  = 2'b01;
    localparam logic [1:0] CMD_LEFT   = 2'b10;
    localparam logic [1:0] CMD_DROP   = 2'b11;

    localparam int CELL_EMPTY = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR_MEM,
        S_CLR_DRAW,
        S_CUR_ERASE,
        S_CUR_DRAW,
        S_SCAN,
        S_DROP_DRAW,
        S_DONE
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Board rows are 1-based (row 0 is the cursor strip), so row 1 maps to address 0.
    function automatic int addr_of(input int row, input int col, input int cols);
        return (row - 1) * cols + col;
    endfunction

endpackage

// File: rtl/board_store.sv
// rtl/board_store.sv - cell register file: one write port, combinational scan read, registered external read
module board_store #(
    parameter int DEPTH  = 42,
    parameter int CELL_W = 2,
    parameter int ADDR_W = 6
) (
    input  logic              i_clk,
    input  logic              i_clr,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [CELL_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_scan_addr,
    output logic [CELL_W-1:0] o_scan_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [CELL_W-1:0] o_rd_data
);

    logic [CELL_W-1:0] r_mem [DEPTH];
    logic [CELL_W-1:0] r_rd_data;

    assign o_scan_data = r_mem[i_scan_addr];
    assign o_rd_data   = r_rd_data;

    // The external read samples the array before this edge's write lands.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_rd_data <= '0;
        end else begin
            if (i_we) r_mem[i_waddr] <= i_wdata;
            r_rd_data <= (int'(i_rd_addr) < DEPTH) ? r_mem[i_rd_addr] : '0;
        end
    end

endmodule

// File: rtl/board_controller.sv
// rtl/board_controller.sv - Connect-N board controller: cursor, turns, drop search and draw sequencing
module board_controller
    import board_pkg::*;
#(
    parameter int COLS    = 7,
    parameter int ROWS    = 6,
    parameter int PLAYERS = 2,
    localparam int DEPTH  = ROWS * COLS,
    localparam int COL_W  = clog2(COLS),
    localparam int ROW_W  = clog2(ROWS + 1),
    localparam int ADDR_W = clog2(DEPTH),
    localparam int CELL_W = clog2(PLAYERS + 1),
    localparam int PLY_W  = (clog2(PLAYERS) > 1) ? clog2(PLAYERS) : 1,
    localparam int MV_W   = clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              resetGame,
    input  logic              clear_req,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd,
    output logic              cmd_ready,
    output logic              cmd_done,
    output logic              col_full,
    output logic              draw_valid,
    input  logic              draw_done,
    output logic [COL_W-1:0]  draw_col,
    output logic [ROW_W-1:0]  draw_row,
    output logic [CELL_W-1:0] draw_cell,
    output logic [PLY_W-1:0]  player,
    output logic [COL_W-1:0]  cursor,
    output logic [MV_W-1:0]   moves,
    output logic              board_full,
    output logic              last_valid,
    output logic [COL_W-1:0]  last_col,
    output logic [ROW_W-1:0]  last_row,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [CELL_W-1:0] rd_data
);

    state_t            r_state;
    logic [COL_W-1:0]  r_cursor, r_old_col, r_col, r_dr_col, r_last_col, r_draw_col;
    logic [ROW_W-1:0]  r_row, r_dr_row, r_last_row, r_draw_row;
    logic [PLY_W-1:0]  r_player;
    logic [MV_W-1:0]   r_moves;
    logic [ADDR_W-1:0] r_clr_addr;
    logic [CELL_W-1:0] r_draw_cell;
    logic              r_phase, r_draw_valid, r_cmd_done, r_col_full, r_last_valid;

    logic              w_we, w_scan_empty, w_draw_state, w_draw_ack;
    logic [ADDR_W-1:0] w_waddr, w_scan_addr;
    logic [CELL_W-1:0] w_wdata, w_scan_data, w_player_cell, w_dcell;
    logic [COL_W-1:0]  w_dcol;
    logic [ROW_W-1:0]  w_drow;

    board_store #(
        .DEPTH  (DEPTH),
        .CELL_W (CELL_W),
        .ADDR_W (ADDR_W)
    ) u_store (
        .i_clk       (clk),
        .i_clr       (resetGame),
        .i_we        (w_we),
        .i_waddr     (w_waddr),
        .i_wdata     (w_wdata),
        .i_scan_addr (w_scan_addr),
        .o_scan_data (w_scan_data),
        .i_rd_addr   (rd_addr),
        .o_rd_data   (rd_data)
    );

    assign w_player_cell = CELL_W'(r_player) + CELL_W'(1);
    assign w_scan_addr   = ADDR_W'(addr_of(int'(r_row), int'(r_col), COLS));
    assign w_scan_empty  = (w_scan_data == CELL_W'(CELL_EMPTY));
    assign w_draw_ack    = r_draw_valid && draw_done;

    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_clr_addr;
        w_wdata = '0;
        if (r_state == S_CLR_MEM) begin
            w_we = 1'b1;
        end else if (r_state == S_SCAN && w_scan_empty) begin
            w_we    = 1'b1;
            w_waddr = w_scan_addr;
            w_wdata = w_player_cell;
        end
    end

    // Coordinates the current state wants drawn; latched when a request is raised.
    always_comb begin
        w_draw_state = 1'b1;
        w_dcol       = r_cursor;
        w_drow       = '0;
        w_dcell      = w_player_cell;
        case (r_state)
            S_CLR_DRAW: begin
                if (!r_phase) begin
                    w_dcol  = r_dr_col;
                    w_drow  = r_dr_row;
                    w_dcell = '0;
                end else begin
                    w_dcol  = '0;
                    w_dcell = CELL_W'(1);
                end
            end
            S_CUR_ERASE: begin
                w_dcol  = r_old_col;
                w_dcell = '0;
            end
            S_CUR_DRAW: begin
                w_dcol = r_cursor;
            end
            S_DROP_DRAW: begin
                if (!r_phase) begin
                    w_dcol = r_col;
                    w_drow = r_row;
                end
            end
            default: w_draw_state = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetGame) begin
            r_state      <= S_CLR_DRAW;
            r_cursor     <= '0;
            r_old_col    <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_dr_col     <= '0;
            r_dr_row     <= '0;
            r_phase      <= 1'b0;
            r_player     <= '0;
            r_moves      <= '0;
            r_clr_addr   <= '0;
            r_draw_valid <= 1'b0;
            r_draw_col   <= '0;
            r_draw_row   <= '0;
            r_draw_cell  <= '0;
            r_cmd_done   <= 1'b0;
            r_col_full   <= 1'b0;
            r_last_valid <= 1'b0;
            r_last_col   <= '0;
            r_last_row   <= '0;
        end else begin
            r_cmd_done   <= 1'b0;
            r_last_valid <= 1'b0;
            // One idle cycle separates consecutive requests: valid drops on the ack edge.
            if (w_draw_state) begin
                if (w_draw_ack) begin
                    r_draw_valid <= 1'b0;
                end else if (!r_draw_valid) begin
                    r_draw_valid <= 1'b1;
                    r_draw_col   <= w_dcol;
                    r_draw_row   <= w_drow;
                    r_draw_cell  <= w_dcell;
                end
            end
            case (r_state)
                S_IDLE: begin
                    r_col_full <= 1'b0;
                    if (clear_req) begin
                        r_clr_addr <= '0;
                        r_state    <= S_CLR_MEM;
                    end else if (cmd_valid) begin
                        case (cmd)
                            CMD_REDRAW: r_state <= S_CUR_DRAW;
                            CMD_RIGHT: begin
                                r_old_col <= r_cursor;
                                r_cursor  <= (r_cursor == COL_W'(COLS - 1)) ? '0 : r_cursor + COL_W'(1);
                                r_state   <= S_CUR_ERASE;
                            end
                            CMD_LEFT: begin
                                r_old_col <= r_cursor;
                                r_cursor  <= (r_cursor == '0) ? COL_W'(COLS - 1) : r_cursor - COL_W'(1);
                                r_state   <= S_CUR_ERASE;
                            end
                            default: begin
                                if (board_full) begin
                                    r_col_full <= 1'b1;
                                    r_state    <= S_DONE;
                                end else begin
                                    r_row   <= ROW_W'(ROWS);
                                    r_col   <= r_cursor;
                                    r_state <= S_SCAN;
                                end
                            end
                        endcase
                    end
                end
                S_CLR_MEM: begin
                    if (r_clr_addr == ADDR_W'(DEPTH - 1)) begin
                        r_cursor <= '0;
                        r_player <= '0;
                        r_moves  <= '0;
                        r_dr_row <= '0;
                        r_dr_col <= '0;
                        r_phase  <= 1'b0;
                        r_state  <= S_CLR_DRAW;
                    end else begin
                        r_clr_addr <= r_clr_addr + ADDR_W'(1);
                    end
                end
                S_CLR_DRAW: begin
                    if (w_draw_ack) begin
                        if (r_phase) begin
                            r_state <= S_DONE;
                        end else if (r_dr_col == COL_W'(COLS - 1)) begin
                            r_dr_col <= '0;
                            if (r_dr_row == ROW_W'(ROWS)) r_phase <= 1'b1;
                            else r_dr_row <= r_dr_row + ROW_W'(1);
                        end else begin
                            r_dr_col <= r_dr_col + COL_W'(1);
                        end
                    end
                end
                S_CUR_ERASE: if (w_draw_ack) r_state <= S_CUR_DRAW;
                S_CUR_DRAW:  if (w_draw_ack) r_state <= S_DONE;
                S_SCAN: begin
                    if (w_scan_empty) begin
                        r_last_col   <= r_col;
                        r_last_row   <= r_row;
                        r_last_valid <= 1'b1;
                        r_moves      <= r_moves + MV_W'(1);
                        r_phase      <= 1'b0;
                        r_state      <= S_DROP_DRAW;
                    end else if (r_row > ROW_W'(1)) begin
                        r_row <= r_row - ROW_W'(1);
                    end else begin
                        r_col_full <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end
                S_DROP_DRAW: begin
                    if (w_draw_ack) begin
                        if (!r_phase) begin
                            r_player <= (r_player == PLY_W'(PLAYERS - 1)) ? '0 : r_player + PLY_W'(1);
                            r_phase  <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                default: begin
                    r_cmd_done <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = (r_state == S_IDLE) && !resetGame;
    assign cmd_done   = r_cmd_done;
    assign col_full   = r_col_full;
    assign draw_valid = r_draw_valid;
    assign draw_col   = r_draw_col;
    assign draw_row   = r_draw_row;
    assign draw_cell  = r_draw_cell;
    assign player     = r_player;
    assign cursor     = r_cursor;
    assign moves      = r_moves;
    assign board_full = (r_moves == MV_W'(DEPTH));
    assign last_valid = r_last_valid;
    assign last_col   = r_last_col;
    assign last_row   = r_last_row;

endmodule

// File: tb/tb_board_controller.sv
// tb/tb_board_controller.sv - directed self-checking bench for board_controller (7x6, 2 and 3 players)
module tb_board_controller;
    import board_pkg::*;

    logic clk, resetGame;
    int   n_pass, n_total, lv_cnt;
    bit   stall;

    logic       a_clear_req, a_cmd_valid, a_cmd_ready, a_cmd_done, a_col_full;
    logic [1:0] a_cmd;
    logic       a_draw_valid, a_draw_done, a_board_full, a_last_valid;
    logic [2:0] a_draw_col, a_draw_row, a_cursor, a_last_col, a_last_row;
    logic [1:0] a_draw_cell, a_rd_data;
    logic [0:0] a_player;
    logic [5:0] a_moves, a_rd_addr;

    logic       b_clear_req, b_cmd_valid, b_cmd_ready, b_cmd_done, b_col_full;
    logic [1:0] b_cmd;
    logic       b_draw_valid, b_draw_done, b_board_full, b_last_valid;
    logic [2:0] b_draw_col, b_draw_row, b_cursor, b_last_col, b_last_row;
    logic [1:0] b_draw_cell, b_rd_data, b_player;
    logic [5:0] b_moves, b_rd_addr;

    logic [11:0] a_q[$];
    bit a_pend, b_pend;
    int a_cnt, b_cnt;

    board_controller dut_a (
        .clk(clk), .resetGame(resetGame), .clear_req(a_clear_req), .cmd_valid(a_cmd_valid),
        .cmd(a_cmd), .cmd_ready(a_cmd_ready), .cmd_done(a_cmd_done), .col_full(a_col_full),
        .draw_valid(a_draw_valid), .draw_done(a_draw_done), .draw_col(a_draw_col),
        .draw_row(a_draw_row), .draw_cell(a_draw_cell), .player(a_player), .cursor(a_cursor),
        .moves(a_moves), .board_full(a_board_full), .last_valid(a_last_valid),
        .last_col(a_last_col), .last_row(a_last_row), .rd_addr(a_rd_addr), .rd_data(a_rd_data)
    );

    board_controller #(.COLS(7), .ROWS(6), .PLAYERS(3)) dut_b (
        .clk(clk), .resetGame(resetGame), .clear_req(b_clear_req), .cmd_valid(b_cmd_valid),
        .cmd(b_cmd), .cmd_ready(b_cmd_ready), .cmd_done(b_cmd_done), .col_full(b_col_full),
        .draw_valid(b_draw_valid), .draw_done(b_draw_done), .draw_col(b_draw_col),
        .draw_row(b_draw_row), .draw_cell(b_draw_cell), .player(b_player), .cursor(b_cursor),
        .moves(b_moves), .board_full(b_board_full), .last_valid(b_last_valid),
        .last_col(b_last_col), .last_row(b_last_row), .rd_addr(b_rd_addr), .rd_data(b_rd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [11:0] pk(input int r, input int c, input int v);
        return {r[3:0], c[3:0], v[3:0]};
    endfunction

    // Drawer model: acknowledges each request two cycles after it first appears.
    initial begin
        a_draw_done = 1'b0;
        a_pend = 0;
        forever begin
            @(negedge clk);
            if (resetGame) begin
                a_pend = 0;
                a_draw_done = 1'b0;
            end else if (a_draw_done) begin
                a_draw_done = 1'b0;
            end else if (!a_draw_valid) begin
                a_pend = 0;
            end else begin
                if (!a_pend) begin
                    a_pend = 1;
                    a_cnt = 0;
                    a_q.push_back({4'(a_draw_row), 4'(a_draw_col), 4'(a_draw_cell)});
                end
                if (!stall) begin
                    a_cnt++;
                    if (a_cnt >= 2) begin
                        a_draw_done = 1'b1;
                        a_pend = 0;
                    end
                end
            end
        end
    end

    initial begin
        b_draw_done = 1'b0;
        b_pend = 0;
        forever begin
            @(negedge clk);
            if (resetGame) begin
                b_pend = 0;
                b_draw_done = 1'b0;
            end else if (b_draw_done) begin
                b_draw_done = 1'b0;
            end else if (!b_draw_valid) begin
                b_pend = 0;
            end else begin
                if (!b_pend) begin
                    b_pend = 1;
                    b_cnt = 0;
                end
                b_cnt++;
                if (b_cnt >= 2) begin
                    b_draw_done = 1'b1;
                    b_pend = 0;
                end
            end
        end
    end

    initial begin
        lv_cnt = 0;
        forever begin
            @(negedge clk);
            if (a_last_valid) lv_cnt++;
        end
    end

    task automatic issue(input int d, input logic [1:0] c, output logic cf);
        int n;
        @(negedge clk);
        n = 0;
        while (!(d == 0 ? a_cmd_ready : b_cmd_ready) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (d == 0) begin a_cmd = c; a_cmd_valid = 1'b1; end
        else begin b_cmd = c; b_cmd_valid = 1'b1; end
        @(negedge clk);
        a_cmd_valid = 1'b0;
        b_cmd_valid = 1'b0;
        n = 0;
        while (!(d == 0 ? a_cmd_done : b_cmd_done) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        cf = (d == 0) ? a_col_full : b_col_full;
        n_total++;
        if (n >= 2000) $display("FAIL cmd_timeout dut=%0d cmd=%0d: no cmd_done, required within 2000 cycles", d, c);
        else n_pass++;
    endtask

    task automatic wait_a_done(input string tag);
        int n;
        n = 0;
        while (!a_cmd_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (n >= 2000) $display("FAIL %s_timeout: no cmd_done, required within 2000 cycles", tag);
        else n_pass++;
    endtask

    task automatic check_clear_draws(input string tag);
        int err;
        err = 0;
        n_total++;
        if (a_q.size() != 50) $display("FAIL %s_draw_count: got %0d, expected 50", tag, a_q.size());
        else n_pass++;
        if (a_q.size() == 50) begin
            for (int k = 0; k < 49; k++) if (a_q[k] !== pk(k / 7, k % 7, 0)) err++;
            n_total++;
            if (err != 0) $display("FAIL %s_grid_order: %0d wrong draws, expected 0", tag, err);
            else n_pass++;
            n_total++;
            if (a_q[49] !== pk(0, 0, 1)) $display("FAIL %s_cursor_draw: got %h, expected %h", tag, a_q[49], pk(0, 0, 1));
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        resetGame = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if (a_draw_valid !== 1'b0 || a_cmd_ready !== 1'b0 || a_rd_data !== 2'd0)
            $display("FAIL reset_outputs: valid=%b ready=%b rd=%0d, expected 0 0 0", a_draw_valid, a_cmd_ready, a_rd_data);
        else n_pass++;
        a_q.delete();
        resetGame = 1'b0;
        wait_a_done("reset");
        check_clear_draws("reset");
        n_total++;
        if (a_player !== 1'd0 || a_moves !== 6'd0 || a_cursor !== 3'd0 || a_board_full !== 1'b0)
            $display("FAIL reset_state: player=%0d moves=%0d cursor=%0d full=%b, expected 0 0 0 0", a_player, a_moves, a_cursor, a_board_full);
        else n_pass++;
    endtask

    task automatic test_cursor();
        logic cf;
        issue(0, CMD_LEFT, cf);
        n_total++;
        if (a_cursor !== 3'd6) $display("FAIL cursor_left_wrap: got %0d, expected 6", a_cursor);
        else n_pass++;
        a_q.delete();
        issue(0, CMD_RIGHT, cf);
        n_total++;
        if (a_q.size() != 2 || a_q[0] !== pk(0, 6, 0) || a_q[1] !== pk(0, 0, 1) || a_cursor !== 3'd0)
            $display("FAIL cursor_right_wrap: draws=%0d cursor=%0d, expected (0,6,0)(0,0,1) cursor 0", a_q.size(), a_cursor);
        else n_pass++;
        a_q.delete();
        issue(0, CMD_REDRAW, cf);
        n_total++;
        if (a_q.size() != 1 || a_q[0] !== pk(0, 0, 1))
            $display("FAIL cursor_redraw: draws=%0d, expected one (0,0,1)", a_q.size());
        else n_pass++;
        issue(0, CMD_LEFT, cf);
        n_total++;
        if (a_cursor !== 3'd6) $display("FAIL cursor_left_again: got %0d, expected 6", a_cursor);
        else n_pass++;
    endtask

    task automatic test_drops();
        logic cf;
        int   lv0;
        repeat (3) issue(0, CMD_LEFT, cf);
        n_total++;
        if (a_cursor !== 3'd3) $display("FAIL drop_cursor: got %0d, expected 3", a_cursor);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            a_q.delete();
            lv0 = lv_cnt;
            issue(0, CMD_DROP, cf);
            n_total++;
            if (cf !== 1'b0 || a_last_row !== 3'(6 - i) || a_last_col !== 3'd3 || a_moves !== 6'(i + 1) ||
                a_player !== 1'((i + 1) % 2) || lv_cnt != lv0 + 1)
                $display("FAIL drop_%0d: full=%b row=%0d col=%0d moves=%0d player=%0d lv=%0d, expected 0 %0d 3 %0d %0d 1",
                         i, cf, a_last_row, a_last_col, a_moves, a_player, lv_cnt - lv0, 6 - i, i + 1, (i + 1) % 2);
            else n_pass++;
            n_total++;
            if (a_q.size() != 2 || a_q[0] !== pk(6 - i, 3, i % 2 + 1) || a_q[1] !== pk(0, 3, (i + 1) % 2 + 1))
                $display("FAIL drop_%0d_draws: count=%0d first=%h, expected %h then %h", i, a_q.size(),
                         (a_q.size() > 0) ? a_q[0] : 12'h0, pk(6 - i, 3, i % 2 + 1), pk(0, 3, (i + 1) % 2 + 1));
            else n_pass++;
        end
        a_q.delete();
        lv0 = lv_cnt;
        issue(0, CMD_DROP, cf);
        n_total++;
        if (cf !== 1'b1 || a_moves !== 6'd6 || a_player !== 1'd0 || a_q.size() != 0 || lv_cnt != lv0)
            $display("FAIL drop_col_full: full=%b moves=%0d player=%0d draws=%0d, expected 1 6 0 0", cf, a_moves, a_player, a_q.size());
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (a_col_full !== 1'b0) $display("FAIL col_full_clear: got %b, expected 0", a_col_full);
        else n_pass++;
    endtask

    task automatic test_players3();
        logic cf;
        int   exp_p [3] = '{1, 2, 0};
        n_total++;
        if (b_player !== 2'd0) $display("FAIL p3_start: got %0d, expected 0", b_player);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) issue(1, CMD_RIGHT, cf);
            issue(1, CMD_DROP, cf);
            n_total++;
            if (b_player !== 2'(exp_p[i])) $display("FAIL p3_turn_%0d: got %0d, expected %0d", i, b_player, exp_p[i]);
            else n_pass++;
        end
        for (int c = 0; c < 3; c++) begin
            b_rd_addr = 6'(35 + c);
            @(negedge clk);
            n_total++;
            if (b_rd_data !== 2'(c + 1)) $display("FAIL p3_read_%0d: got %0d, expected %0d", c, b_rd_data, c + 1);
            else n_pass++;
        end
        b_rd_addr = 6'd42;
        @(negedge clk);
        n_total++;
        if (b_rd_data !== 2'd0) $display("FAIL p3_read_oob: got %0d, expected 0", b_rd_data);
        else n_pass++;
    endtask

    task automatic test_clear();
        logic cf;
        int   n, err;
        issue(0, CMD_RIGHT, cf);
        repeat (4) issue(0, CMD_DROP, cf);
        n_total++;
        if (a_moves !== 6'd10) $display("FAIL clear_pre_moves: got %0d, expected 10", a_moves);
        else n_pass++;
        a_q.delete();
        @(negedge clk);
        a_clear_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            a_clear_req = 1'b0;
        end while (!a_draw_valid && n < 200);
        n_total++;
        if (n != 44) $display("FAIL clear_mem_cycles: first draw after %0d cycles, expected 44", n);
        else n_pass++;
        wait_a_done("clear");
        check_clear_draws("clear");
        n_total++;
        if (a_moves !== 6'd0 || a_cursor !== 3'd0 || a_player !== 1'd0)
            $display("FAIL clear_state: moves=%0d cursor=%0d player=%0d, expected 0 0 0", a_moves, a_cursor, a_player);
        else n_pass++;
        err = 0;
        for (int i = 0; i < 42; i++) begin
            a_rd_addr = 6'(i);
            @(negedge clk);
            if (a_rd_data !== 2'd0) err++;
        end
        n_total++;
        if (err != 0) $display("FAIL clear_cells: %0d nonzero cells, expected 0", err);
        else n_pass++;
    endtask

    task automatic test_reset_mid_draw();
        int n;
        stall = 1;
        a_rd_addr = 6'd35;
        @(negedge clk);
        n = 0;
        while (!a_cmd_ready && n < 100) begin @(negedge clk); n++; end
        a_cmd = CMD_DROP;
        a_cmd_valid = 1'b1;
        @(negedge clk);
        a_cmd_valid = 1'b0;
        n = 0;
        while (!a_draw_valid && n < 50) begin @(negedge clk); n++; end
        n_total++;
        if (a_draw_valid !== 1'b1 || a_rd_data !== 2'd1)
            $display("FAIL mid_pre_reset: valid=%b rd=%0d, expected 1 1", a_draw_valid, a_rd_data);
        else n_pass++;
        resetGame = 1'b1;
        @(negedge clk);
        n_total++;
        if (a_draw_valid !== 1'b0 || a_cmd_ready !== 1'b0)
            $display("FAIL mid_reset_abandon: valid=%b ready=%b, expected 0 0", a_draw_valid, a_cmd_ready);
        else n_pass++;
        resetGame = 1'b0;
        stall = 0;
        a_q.delete();
        wait_a_done("mid");
        check_clear_draws("mid");
        n_total++;
        if (a_moves !== 6'd0 || a_rd_data !== 2'd0)
            $display("FAIL mid_state: moves=%0d rd=%0d, expected 0 0", a_moves, a_rd_data);
        else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        stall = 0;
        resetGame = 1'b1;
        a_clear_req = 1'b0; a_cmd_valid = 1'b0; a_cmd = 2'b00; a_rd_addr = '0;
        b_clear_req = 1'b0; b_cmd_valid = 1'b0; b_cmd = 2'b00; b_rd_addr = '0;
        test_reset();
        test_cursor();
        test_drops();
        test_players3();
        test_clear();
        test_reset_mid_draw();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
